// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC job sequencer slice.
// Provides default widths and the sequencer state encoding.
package mac_seq_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 16;
  localparam int unsigned DEF_CNT_W  = 3;
  localparam int unsigned DEF_ITERS  = 8;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ITER,
    S_ACC,
    S_SETTLE,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/mac_iter_timer.sv
// Multiplier step timer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : clear the step counter to 0
//   en          : advance the step counter by one
//   step        : current step value
//   first_step  : step == 0
//   last_step   : step == ITERS-1
module mac_iter_timer #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned ITERS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] step,
  output logic             first_step,
  output logic             last_step
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (load) begin
      step <= '0;
    end else if (en) begin
      step <= step + CNT_W'(1);
    end
  end

  always_comb begin
    first_step = (step == '0);
    last_step  = (step == LAST);
  end

endmodule

// File: rtl/mac_job_sequencer.sv
// Sequences one MAC through an L-term dot product and returns the job sum.
// The MAC accumulator is never cleared, so the sum is mac_out at the end
// minus mac_out captured on accept (modulo 2^ACC_W).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   job_valid/job_ready/job_len: job request handshake and length L
//   op_rd/op_addr/op_a/op_w    : operand memory read (data one cycle later)
//   mac_an/mac_wn/mac_counter  : MAC operands and step counter
//   mac_start/mac_stop/mac_out : MAC strobes and accumulator output
//   res_valid/res_data/res_ready: result handshake
//   busy                       : high whenever not idle
module mac_job_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned ITERS  = DEF_ITERS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [ADDR_W:0]   job_len,
  output logic              op_rd,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_w,
  output logic [DATA_W-1:0] mac_an,
  output logic [DATA_W-1:0] mac_wn,
  output logic [CNT_W-1:0]  mac_counter,
  output logic              mac_start,
  output logic              mac_stop,
  input  logic [ACC_W-1:0]  mac_out,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  input  logic              res_ready,
  output logic              busy
);

  seq_state_e state, state_next;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [ACC_W-1:0]  base_q;
  logic [DATA_W-1:0] an_q;
  logic [DATA_W-1:0] wn_q;
  logic [ACC_W-1:0]  res_q;

  logic             accept;
  logic [CNT_W-1:0] step;
  logic             first_step;
  logic             last_step;

  assign accept = job_valid && (state == S_IDLE);

  mac_iter_timer #(
    .CNT_W (CNT_W),
    .ITERS (ITERS)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == S_LOAD),
    .en         (state == S_ITER),
    .step       (step),
    .first_step (first_step),
    .last_step  (last_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (accept) state_next = (job_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:  state_next = S_LOAD;
      S_LOAD:   state_next = S_ITER;
      S_ITER:   if (last_step) state_next = S_ACC;
      // idx_q still holds the pair just finished; compare its successor with L.
      S_ACC:    state_next = ((idx_q + (ADDR_W+1)'(1)) < len_q) ? S_FETCH : S_SETTLE;
      S_SETTLE: state_next = S_DONE;
      S_DONE:   if (res_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      idx_q  <= '0;
      base_q <= '0;
      an_q   <= '0;
      wn_q   <= '0;
      res_q  <= '0;
    end else begin
      if (accept) begin
        len_q  <= job_len;
        idx_q  <= '0;
        base_q <= mac_out;
        if (job_len == '0) res_q <= '0;
      end
      if (state == S_LOAD) begin
        an_q <= op_a;
        wn_q <= op_w;
      end
      if (state == S_ACC) idx_q <= idx_q + (ADDR_W+1)'(1);
      // Wrapping subtraction recovers the job sum from the uncleared accumulator.
      if (state == S_SETTLE) res_q <= mac_out - base_q;
    end
  end

  always_comb begin
    job_ready   = (state == S_IDLE);
    busy        = (state != S_IDLE);
    op_rd       = (state == S_FETCH);
    op_addr     = (state == S_FETCH) ? idx_q[ADDR_W-1:0] : '0;
    mac_counter = (state == S_ITER) ? step : '0;
    mac_start   = (state == S_ITER) && first_step;
    mac_stop    = (state == S_ACC);
    res_valid   = (state == S_DONE);
    mac_an      = an_q;
    mac_wn      = wn_q;
    res_data    = res_q;
  end

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Self-checking bench for mac_job_sequencer with a behavioural MAC and operand RAM.
module tb_mac_job_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 3;
  localparam int ITERS  = 8;
  localparam int ADDR_W = 4;
  localparam int PER    = ITERS + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W:0]   job_len;
  logic              op_rd;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_w;
  logic [DATA_W-1:0] mac_an;
  logic [DATA_W-1:0] mac_wn;
  logic [CNT_W-1:0]  mac_counter;
  logic              mac_start;
  logic              mac_stop;
  logic [ACC_W-1:0]  mac_out;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_job_sequencer #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W),
    .ITERS  (ITERS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_len     (job_len),
    .op_rd       (op_rd),
    .op_addr     (op_addr),
    .op_a        (op_a),
    .op_w        (op_w),
    .mac_an      (mac_an),
    .mac_wn      (mac_wn),
    .mac_counter (mac_counter),
    .mac_start   (mac_start),
    .mac_stop    (mac_stop),
    .mac_out     (mac_out),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  // Behavioural MAC: accumulates An*Wn on each stop, never cleared.
  logic [ACC_W-1:0] acc;
  logic             preload_en;
  logic [ACC_W-1:0] preload_val;
  always @(posedge clk) begin
    if (preload_en) acc <= preload_val;
    else if (mac_stop) acc <= acc + ACC_W'({8'd0, mac_an} * {8'd0, mac_wn});
  end
  assign mac_out = acc;

  // Operand RAM with one cycle read latency.
  logic [DATA_W-1:0] mem_a [16];
  logic [DATA_W-1:0] mem_w [16];
  always @(posedge clk) begin
    if (op_rd) begin
      op_a <= mem_a[op_addr];
      op_w <= mem_w[op_addr];
    end
  end

  function automatic logic [ACC_W-1:0] ref_sum(input int len);
    logic [ACC_W-1:0] s;
    s = '0;
    for (int i = 0; i < len; i++) s = s + ACC_W'({8'd0, mem_a[i]} * {8'd0, mem_w[i]});
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = DATA_W'($urandom);
      mem_w[i] = DATA_W'($urandom);
    end
  endtask

  task automatic preload(input logic [ACC_W-1:0] v);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_val = v;
    @(negedge clk);
    preload_en  = 1'b0;
  endtask

  // One complete job: accept, per-cycle timeline against the expected schedule,
  // result value, DONE hold for 'hold' cycles, and release.
  task automatic run_job(input int len, input int hold);
    int lat, first, tl_bad, stab_bad, p, o, e_addr, e_cnt;
    logic e_rd, e_st, e_sp, chk_ops;
    logic [12:0] exp_v, obs_v;
    logic [ACC_W-1:0] exp_sum;
    exp_sum = ref_sum(len);
    lat = (len == 0) ? 1 : len * PER + 2;
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_accept len=%0d got ready=%b busy=%b required 1/0", len, job_ready, busy);
    end
    job_valid = 1'b1;
    job_len   = 5'(len);
    res_ready = 1'b0;
    first  = -1;
    tl_bad = 0;
    for (int k = 1; k <= lat + 5; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        first = k;
        break;
      end
      p = (k - 1) / PER;
      o = (k - 1) % PER;
      e_rd = 1'b0; e_st = 1'b0; e_sp = 1'b0; e_addr = 0; e_cnt = 0; chk_ops = 1'b0;
      if (len > 0 && p < len) begin
        e_rd = (o == 0);
        e_addr = (o == 0) ? p : 0;
        e_st = (o == 2);
        e_sp = (o == PER - 1);
        if (o >= 2 && o <= ITERS + 1) e_cnt = o - 2;
        chk_ops = (o >= 2);
      end
      exp_v = {e_rd, 4'(e_addr), e_st, e_sp, 3'(e_cnt), 1'b1, 1'b0, 1'b0};
      obs_v = {op_rd, op_addr, mac_start, mac_stop, mac_counter, busy, job_ready, res_valid};
      if (obs_v !== exp_v || (chk_ops && (mac_an !== mem_a[p] || mac_wn !== mem_w[p]))) begin
        if (tl_bad == 0)
          $display("FAIL timeline len=%0d cycle %0d got %b an=%h wn=%h required %b", len, k, obs_v, mac_an, mac_wn, exp_v);
        tl_bad++;
      end
      job_valid = 1'($urandom);
      job_len   = 5'($urandom);
      res_ready = 1'($urandom);
    end
    checks++;
    if (tl_bad != 0) begin
      errors++;
      $display("FAIL timeline_total len=%0d got %0d bad cycles required 0", len, tl_bad);
    end
    checks++;
    if (first != lat) begin
      errors++;
      $display("FAIL latency len=%0d got %0d required %0d", len, first, lat);
    end
    checks++;
    if (res_data !== exp_sum) begin
      errors++;
      $display("FAIL sum len=%0d got %h required %h", len, res_data, exp_sum);
    end
    stab_bad = 0;
    for (int h = 0; h < hold; h++) begin
      job_valid = 1'($urandom);
      res_ready = 1'b0;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== exp_sum || job_ready !== 1'b0 || busy !== 1'b1 ||
          {op_rd, mac_start, mac_stop} !== 3'b000)
        stab_bad++;
    end
    checks++;
    if (stab_bad != 0 || {op_rd, mac_start, mac_stop} !== 3'b000) begin
      errors++;
      $display("FAIL done_hold len=%0d got %0d bad cycles strobes=%b required 0", len, stab_bad, {op_rd, mac_start, mac_stop});
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release len=%0d got valid=%b ready=%b busy=%b required 0/1/0", len, res_valid, job_ready, busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [44:0] obs, exp_v;
    obs = {job_ready, busy, op_rd, op_addr, mac_an, mac_wn, mac_counter,
           mac_start, mac_stop, res_valid, res_data};
    exp_v = '0;
    exp_v[44] = 1'b1;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h required %h", tag, obs, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_len = '0;
    res_ready = 1'b0;
    preload_en = 1'b1;
    preload_val = '0;
    fill_random();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    preload_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    mem_a[0] = 8'd3;
    mem_w[0] = 8'd4;
    run_job(1, 0);
    checks++;
    if (acc !== 16'd12) begin
      errors++;
      $display("FAIL single_acc got %h required %h", acc, 16'd12);
    end
  endtask

  task automatic test_four();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(2 * i + 1);
      mem_w[i] = 8'(2 * i + 2);
    end
    run_job(4, 0);
  endtask

  task automatic test_wrap();
    preload(16'hFFF0);
    mem_a[0] = 8'd4;
    mem_w[0] = 8'd8;
    run_job(1, 0);
    checks++;
    if (acc !== 16'h0010) begin
      errors++;
      $display("FAIL wrap_acc got %h required %h", acc, 16'h0010);
    end
  endtask

  task automatic test_empty();
    run_job(0, 0);
  endtask

  task automatic test_hold();
    fill_random();
    run_job(2, 5);
  endtask

  task automatic test_abort();
    fill_random();
    @(negedge clk);
    job_valid = 1'b1;
    job_len = 5'd4;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (mac_counter !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_midjob got counter=%0d busy=%b required 2/1", mac_counter, busy);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_job(1, 1);
  endtask

  task automatic test_full();
    fill_random();
    run_job(16, 1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      if ($urandom_range(0, 3) == 0) preload(ACC_W'($urandom));
      fill_random();
      run_job(int'($urandom_range(0, 16)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four();
    test_wrap();
    test_empty();
    test_hold();
    test_abort();
    test_full();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
